// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state type, frame constants and the majority-vote helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} uart_rx_state_t;
  localparam int DATA_BITS = 8;
  localparam int MIN_CLKS_PER_BIT = 16;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer plus previous-value flop; ports clk, n_rst, rx_i -> sync_o (synchronized line), fall_o (1->0 edge)
module uart_rx_sync (
  input  logic clk,
  input  logic n_rst,
  input  logic rx_i,
  output logic sync_o,
  output logic fall_o
);
  logic meta_q, sync_q, prev_q;
  always_ff @(posedge clk or posedge n_rst)
    if (n_rst) {meta_q, sync_q, prev_q} <= '0;
    else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver; ports clk, n_rst, rx (serial in), data/valid/ready (byte out), frame_err, overrun (pulses), busy
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_cpb_check
    $error("CLKS_PER_BIT must be at least %0d", MIN_CLKS_PER_BIT);
  end
  logic rx_s, fall, vote;
  uart_rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic [1:0] hist_q;
  logic valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  uart_rx_sync u_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .rx_i  (rx),
    .sync_o(rx_s),
    .fall_o(fall)
  );
  assign vote = maj3(hist_q[1], hist_q[0], rx_s);
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = valid_q & ~ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE:      state_d = fall ? START : IDLE;
      START:     if (cnt_q == HALF) state_d = vote ? IDLE : DATA;
      DATA:
        if (cnt_q == LAST) begin
          sh_d  = {vote, sh_q[DATA_BITS-1:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'(DATA_BITS - 1)) state_d = STOP;
        end
      STOP:
        if (cnt_q == LAST) begin
          state_d = vote ? IDLE : WAIT_HIGH;
          ferr_d  = ~vote;
          if (vote && (!valid_q || ready)) begin
            data_d  = sh_q;
            valid_d = 1'b1;
          end
          ovr_d = vote & valid_q & ~ready;
        end
      WAIT_HIGH: state_d = rx_s ? IDLE : WAIT_HIGH;
      default:   state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
      bit_d = '0;
    end
  end
  always_ff @(posedge clk or posedge n_rst)
    if (n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      hist_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      hist_q  <= {hist_q[0], rx_s};
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx with a frame-level reference model
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int DEC = 2 + CPB / 2 + 9 * CPB + 1;
  logic clk = 1'b0, n_rst = 1'b1, rx = 1'b1, ready = 1'b0;
  logic [7:0] data;
  logic valid, frame_err, overrun, busy;
  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .n_rst(n_rst), .rx(rx), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, failures = 0;
  typedef struct {int kind; logic [7:0] d; int at;} evt_t;
  typedef struct {logic [7:0] d; bit ok; int dc;} frm_t;
  evt_t exp_q[$];
  frm_t pend[$];
  bit m_full = 0, rand_ready = 0, acc = 0, pv = 0;
  logic [7:0] pd = 8'h00;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask
  task automatic take(input int kind, input logic [7:0] d);
    evt_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind %0d data 0x%0h at cycle %0d, expected no event", kind, d, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == 0) chk("event_data", int'(d), int'(e.d));
      chk("event_cycle", cyc, e.at);
    end
  endtask
  always @(posedge clk) begin
    frm_t f;
    bit hit, ld;
    if (n_rst) begin
      m_full = 0;
      pend.delete();
    end else begin
      hit = 0;
      ld  = 0;
      if (pend.size() > 0 && pend[0].dc == cyc) begin
        hit = 1;
        f = pend.pop_front();
      end
      if (hit) begin
        if (!f.ok) exp_q.push_back('{1, 8'h00, cyc + 1});
        else if (!m_full || ready) begin
          exp_q.push_back('{0, f.d, cyc + 1});
          ld = 1;
        end else exp_q.push_back('{2, 8'h00, cyc + 1});
      end
      m_full = ld ? 1'b1 : (ready ? 1'b0 : m_full);
    end
  end
  always @(posedge clk) acc = n_rst ? 1'b0 : (valid && ready);
  always @(negedge clk) begin
    if (n_rst) pv = 0;
    else begin
      if (valid && (!pv || acc)) take(0, data);
      if (pv && valid && !acc) chk("data_stable", int'(data), int'(pd));
      if (frame_err) take(1, 8'h00);
      if (overrun) take(2, 8'h00);
      pv = valid;
      pd = data;
    end
  end
  always @(negedge clk) if (rand_ready) ready = 1'($urandom_range(0, 1));
  task automatic drive(input logic [9:0] b, input int n, input int g, input bit rec, output int c0);
    c0 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        c0 = cyc;
        if (rec) pend.push_back('{b[8:1], b[9], cyc + DEC});
      end
      rx = b[i / CPB] ^ (i == g);
    end
  endtask
  task automatic send(input logic [7:0] d, input bit ok, input int g, output int c0);
    drive({ok, d, 1'b0}, 10 * CPB, g, 1'b1, c0);
  endtask
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion by cycle %0d, expected finish", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    int c, c1, gap;
    logic [7:0] d;
    bit ok;
    repeat (3) @(negedge clk);
    chk("rst_data", int'(data), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_busy", int'(busy), 0);
    n_rst = 1'b0;
    repeat (5) @(negedge clk);
    ready = 1'b1;
    send(8'hA5, 1'b1, -1, c);
    repeat (20) @(negedge clk);
    chk("a5_valid_pulse_done", int'(valid), 0);
    @(negedge clk);
    c = cyc;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    wait_cyc(c + 11);
    chk("abort_busy_at_vote", int'(busy), 1);
    wait_cyc(c + 12);
    chk("abort_busy_idle", int'(busy), 0);
    repeat (10) @(negedge clk);
    send(8'h00, 1'b1, CPB / 2 + 4 * CPB, c);
    repeat (10) @(negedge clk);
    send(8'h3C, 1'b0, -1, c);
    repeat (3 * CPB) @(negedge clk);
    chk("break_busy_wait_high", int'(busy), 1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("break_busy_released", int'(busy), 0);
    repeat (10) @(negedge clk);
    ready = 1'b0;
    send(8'h01, 1'b1, -1, c1);
    send(8'h02, 1'b1, -1, c);
    repeat (10) @(negedge clk);
    chk("ovr_data_kept", int'(data), 8'h01);
    chk("ovr_valid_kept", int'(valid), 1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("ovr_drained", int'(valid), 0);
    send(8'h01, 1'b1, -1, c1);
    fork
      send(8'h02, 1'b1, -1, c);
      begin
        wait_cyc(c1 + 10 * CPB + DEC);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    chk("accept_data_new", int'(data), 8'h02);
    chk("accept_valid_held", int'(valid), 1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    repeat (5) @(negedge clk);
    send(8'h77, 1'b1, -1, c);
    repeat (5) @(negedge clk);
    drive({1'b1, 8'hFF, 1'b0}, CPB + 4 * CPB + CPB / 2, -1, 1'b0, c);
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_valid", int'(valid), 1);
    #2 n_rst = 1'b1;
    #1;
    chk("mid_rst_data", int'(data), 0);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_frame_err", int'(frame_err), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    @(negedge clk);
    #2 n_rst = 1'b0;
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    ready = 1'b1;
    send(8'h5A, 1'b1, -1, c);
    repeat (20) @(negedge clk);
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      ok = $urandom_range(0, 4) != 0;
      send(d, ok, -1, c);
      gap = $urandom_range(ok ? 0 : 1, 12);
      repeat (gap) begin
        @(negedge clk);
        rx = 1'b1;
      end
    end
    rand_ready = 1'b0;
    @(negedge clk);
    ready = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("model_frames_done", pend.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the FTDI `usb_rx` line. It decodes 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) into bytes and presents them on a valid/ready output. It sits between the board's `usb_rx` pin and the user logic that consumes host bytes, for example the LED driver. The existing transmit path is unaffected.

## Interface
Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit (100 MHz / 115200). Legal range ≥ 16; elaboration fails below that.

Ports:
- clk  input  1  design clock
- n_rst  input  1  reset, asynchronous, active-high
- rx  input  1  raw serial line; idle high; asynchronous to clk
- data  output  8  received byte; valid only while `valid` = 1
- valid  output  1  byte available in the holding register
- ready  input  1  consumer accepts the byte on a cycle where valid && ready
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: byte completed while the holding register was full and not being emptied
- busy  output  1  FSM is not in IDLE

## Operation
- `rx` passes through a 2-flop synchronizer; a third flop holds the previous synchronized value for edge detection.
- Start detect: the synchronized value is 0 and the previous value is 1.
- FSM states:
  - IDLE → START on start detect.
  - START: wait CLKS_PER_BIT/2 (integer division) to reach the bit center, then vote. If the vote is 1 (false start or glitch), go to IDLE. Otherwise go to DATA.
  - DATA: 8 bits, one vote per bit at CLKS_PER_BIT intervals. Shift right into the shift register, MSB entering, so bit 0 ends in data[0]. After the 8th bit → STOP.
  - STOP: vote one bit later. If the vote is 1, deliver the byte and go to IDLE. If the vote is 0, pulse frame_err, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH → IDLE once the synchronized rx is 1. This prevents a break condition from retriggering.
- Vote: 2-of-3 majority of synchronized samples at center−1, center, and center+1. The decision is made on the center+1 cycle.
- Baud counter: counts 0..CLKS_PER_BIT−1 and wraps. Width is $clog2(CLKS_PER_BIT). The counter is zeroed on every state entry. The bit counter is 3 bits.
- Delivery:
  - If the holding register is empty, or valid && ready in the same cycle, load `data` and set `valid`.
  - Otherwise pulse `overrun`, drop the new byte, and keep the old byte.
- `valid` clears on valid && ready when no new byte loads in that cycle.
- `data` is stable while valid is high.

## Timing
- Reset values: data = 0x00, valid = 0, frame_err = 0, overrun = 0, busy = 0. The FSM resets to IDLE.
- The synchronizer and previous-value flops reset to 0, so a line held low through reset is not seen as a start edge.
- Reset mid-frame aborts immediately and discards any partial byte. No pulse is emitted.
- Define t0 as the first cycle the synchronized rx is low (the raw edge plus 2 cycles).
- Vote for bit k (0 = start, 1..8 = data, 9 = stop) is decided at t0 + CLKS_PER_BIT/2 + k·CLKS_PER_BIT + 1.
- valid, or frame_err, or overrun rises on the cycle after the stop decision: t0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 2.
- The FSM is back in IDLE that same cycle, so a start edge falling half a bit after the stop center is caught. This tolerates about ±4% baud mismatch.
- `ready` has no combinational path to any output. Acceptance takes effect on the next edge.

## Structure
- Package uart_pkg holds:
  - `uart_rx_state_t` enum {IDLE, START, DATA, STOP, WAIT_HIGH}
  - localparam DATA_BITS = 8
  - MIN_CLKS_PER_BIT = 16
- Sub-module uart_rx_sync contains the 2-flop synchronizer, the previous-value flop, and the `fall` output. It is reusable by a later uart_tx loopback checker.
- All remaining logic lives in uart_rx: the FSM, the counters, the majority vote, and the holding register. Estimated size is about 200 lines.

## Test plan
All scenarios use CLKS_PER_BIT = 16.
- 0xA5 frame, ready tied 1 → valid pulses for one cycle with data = 0xA5, at t0 + 154. frame_err and overrun stay 0.
- rx low for 4 cycles, then high → START aborts at t0 + 9, no valid, busy returns to 0. Also: a single-cycle high spike at bit-3 center of 0x00 → majority still yields 0x00.
- 0x3C with stop bit held low, rx low for 3 more bit times → frame_err pulses once, no valid, and no new start is detected until rx goes high.
- 0x01 then 0x02 back-to-back with ready = 0 → valid stays high with data = 0x01, overrun pulses at the second stop decision, data remains 0x01.
- Same two frames, ready asserted exactly on the cycle the 0x02 stop decision lands → no overrun, data = 0x02 the next cycle, valid stays 1.
- n_rst pulsed during data bit 4 → all outputs go to reset values asynchronously. A following 0x5A frame is received correctly with no frame_err.
